// File: rtl/cdc_wr_bridge.sv
// Write-side front end for the single-entry async CDC FIFO (wclk domain).
// Buffers one source beat and turns valid/ready into a one-cycle push pulse with full-flag handshake checking.
module cdc_wr_bridge #(
  parameter int DATA_W  = 51,
  parameter int TIMEOUT = 4
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              fifo_wpush,
  output logic [DATA_W-1:0] fifo_wdata,
  input  logic              fifo_wfull,
  output logic              busy,
  output logic              err,
  output logic [15:0]       push_cnt,
  output logic [1:0]        dbg_state
);

  // Source handshake: a beat transfers on a wclk edge where s_valid and s_ready are
  // both high; s_ready depends only on the hold register, never on s_valid.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH     = 2'd1,
    ST_WAIT_SET = 2'd2,
    ST_WAIT_CLR = 2'd3
  } state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_hold_valid;
  logic [DATA_W-1:0]   r_hold_data;
  logic                r_wpush;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_err;
  logic [15:0]         r_push_cnt;
  logic [3:0]          r_tmo;

  logic                w_accept;
  logic                w_push_start;
  logic                w_push_done;
  logic                w_tmo_clr;
  logic                w_tmo_inc;
  logic                w_set_err;

  assign w_accept    = s_valid & ~r_hold_valid;
  assign w_push_done = (r_state == ST_PUSH);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_push_start = 1'b0;
    w_tmo_clr    = 1'b0;
    w_tmo_inc    = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_valid && !fifo_wfull) begin
          w_next       = ST_PUSH;
          w_push_start = 1'b1;
        end
      end
      ST_PUSH: begin
        w_next    = ST_WAIT_SET;
        w_tmo_clr = 1'b1;
      end
      ST_WAIT_SET: begin
        // The FIFO must acknowledge the push by raising its full flag.
        if (fifo_wfull) begin
          w_next = ST_WAIT_CLR;
        end else if (r_tmo == TMO_LAST) begin
          w_next    = ST_IDLE;
          w_set_err = 1'b1;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end
      ST_WAIT_CLR: begin
        if (!fifo_wfull) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // s_ready is low throughout PUSH, so an accept and the PUSH-exit clear never collide.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= s_data;
    end else if (w_push_done) begin
      r_hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wpush <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_wpush <= w_push_start;
      if (w_push_start) begin
        r_wdata <= r_hold_data;
      end
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_tmo <= 4'd0;
    end else if (w_tmo_clr) begin
      r_tmo <= 4'd0;
    end else if (w_tmo_inc) begin
      r_tmo <= r_tmo + 4'd1;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_push_cnt <= 16'd0;
    end else if (w_push_done) begin
      r_push_cnt <= r_push_cnt + 16'd1;
    end
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_err <= 1'b0;
    end else if (w_set_err) begin
      r_err <= 1'b1;
    end
  end

  assign s_ready    = ~r_hold_valid;
  assign fifo_wpush = r_wpush;
  assign fifo_wdata = r_wdata;
  assign busy       = (r_state != ST_IDLE) | r_hold_valid;
  assign err        = r_err;
  assign push_cnt   = r_push_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cdc_wr_bridge.sv
// Bench for cdc_wr_bridge: directed vector table plus hand sequences, with a
// behavioural FIFO full-flag model and a push scoreboard.
module tb_cdc_wr_bridge;

  localparam int DW = 51;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PUSH = 2'd1;
  localparam logic [1:0] S_WSET = 2'd2;
  localparam logic [1:0] S_WCLR = 2'd3;

  logic          wclk;
  logic          wrst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          fifo_wpush;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_wfull;
  logic          busy;
  logic          err;
  logic [15:0]   push_cnt;
  logic [1:0]    dbg_state;

  cdc_wr_bridge #(.DATA_W(DW), .TIMEOUT(4)) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .fifo_wpush (fifo_wpush),
    .fifo_wdata (fifo_wdata),
    .fifo_wfull (fifo_wfull),
    .busy       (busy),
    .err        (err),
    .push_cnt   (push_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic [DW-1:0] exp_q[$];

  // FIFO full-flag model, evaluated 2 time units after each rising edge
  bit fm_manual = 1'b0;
  bit man_full  = 1'b0;
  bit fm_never  = 1'b0;
  int fm_hold   = 6;
  int rise_cd   = 0;
  int hold_cd   = 0;

  initial fifo_wfull = 1'b0;

  always begin
    @(posedge wclk);
    #2;
    if (wrst) begin
      fifo_wfull = 1'b0;
      rise_cd    = 0;
      hold_cd    = 0;
    end else if (fm_manual) begin
      fifo_wfull = man_full;
    end else if (fifo_wpush && !fm_never) begin
      rise_cd = 2;
    end else if (rise_cd > 0) begin
      rise_cd--;
      if (rise_cd == 0) begin
        fifo_wfull = 1'b1;
        hold_cd    = fm_hold;
      end
    end else if (fifo_wfull) begin
      if (hold_cd > 0) hold_cd--;
      if (hold_cd == 0) fifo_wfull = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // push monitor / scoreboard
  bit prev_push = 1'b0;
  int gap = 99;

  always @(negedge wclk) begin
    if (wrst) begin
      prev_push = 1'b0;
      gap       = 99;
    end else begin
      if (fifo_wpush) begin
        pulses++;
        chk("push_width", 64'(prev_push), 64'd0);
        chk("push_gap_ge3", 64'(gap >= 3), 64'd1);
        chk("push_while_full", 64'(fifo_wfull), 64'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_push: got data %0h with empty expected queue", fifo_wdata);
        end else begin
          chk("push_data", 64'(fifo_wdata), 64'(exp_q.pop_front()));
        end
        gap = 0;
      end else begin
        gap++;
      end
      prev_push = fifo_wpush;
    end
  end

  // driver tasks: called and returning on a falling edge
  task automatic send(input logic [DW-1:0] d, input bit keep);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      if (s_ready) begin
        exp_q.push_back(d);
        done = 1'b1;
      end
      @(negedge wclk);
    end
    if (!done) fail_now("send_accept");
    if (!keep) s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!busy && !fifo_wfull) ok = 1'b1;
      else @(negedge wclk);
    end
    if (!ok) fail_now(name);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            hold;
    logic [15:0]   exp_cnt;
  } vec_t;

  vec_t vecs[3];
  int p0;
  logic [DW-1:0] d_single;

  initial begin
    vecs[0] = '{data: 51'h0,                hold: 1,  exp_cnt: 16'd2};
    vecs[1] = '{data: 51'h7_FFFF_FFFF_FFFF, hold: 3,  exp_cnt: 16'd3};
    vecs[2] = '{data: 51'h5_5555_AAAA_5555, hold: 10, exp_cnt: 16'd4};
    d_single = 51'h1_2345_6789_ABCD;

    wrst    = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (3) @(negedge wclk);

    // reset values
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_wpush", 64'(fifo_wpush), 64'd0);
    chk("rst_wdata", 64'(fifo_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_push_cnt", 64'(push_cnt), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    wrst = 1'b0;
    @(negedge wclk);

    // single beat with exact timing
    fm_hold = 6;
    send(d_single, 1'b0);
    chk("sb_s_ready_low", 64'(s_ready), 64'd0);
    chk("sb_busy", 64'(busy), 64'd1);
    chk("sb_no_push_yet", 64'(fifo_wpush), 64'd0);
    @(negedge wclk);
    chk("sb_push", 64'(fifo_wpush), 64'd1);
    chk("sb_state_push", 64'(dbg_state), 64'(S_PUSH));
    chk("sb_wdata", 64'(fifo_wdata), 64'(d_single));
    @(negedge wclk);
    chk("sb_push_end", 64'(fifo_wpush), 64'd0);
    chk("sb_state_wset", 64'(dbg_state), 64'(S_WSET));
    chk("sb_cnt_1", 64'(push_cnt), 64'd1);
    chk("sb_s_ready_back", 64'(s_ready), 64'd1);
    @(negedge wclk);
    chk("sb_state_wset2", 64'(dbg_state), 64'(S_WSET));
    @(negedge wclk);
    chk("sb_state_wclr", 64'(dbg_state), 64'(S_WCLR));
    wait_idle("sb_idle");
    chk("sb_busy_end", 64'(busy), 64'd0);
    chk("sb_state_end", 64'(dbg_state), 64'(S_IDLE));
    chk("sb_wdata_held", 64'(fifo_wdata), 64'(d_single));

    // vector table: payload / full-flag hold time / expected count
    for (int v = 0; v < 3; v++) begin
      fm_hold = vecs[v].hold;
      send(vecs[v].data, 1'b0);
      wait_idle("vec_idle");
      chk("vec_cnt", 64'(push_cnt), 64'(vecs[v].exp_cnt));
      chk("vec_wdata_held", 64'(fifo_wdata), 64'(vecs[v].data));
      chk("vec_busy", 64'(busy), 64'd0);
      chk("vec_err", 64'(err), 64'd0);
    end

    // back-to-back with a slow reader
    fm_hold = 20;
    p0 = pulses;
    send(51'h0_0000_0000_0011, 1'b1);
    send(51'h0_0000_0000_0022, 1'b1);
    send(51'h0_0000_0000_0033, 1'b1);
    send(51'h0_0000_0000_0044, 1'b0);
    wait_idle("b2b_idle");
    chk("b2b_pulses", 64'(pulses - p0), 64'd4);
    chk("b2b_cnt", 64'(push_cnt), 64'd8);

    // blocked start: full flag already high when the beat arrives
    fm_hold   = 6;
    man_full  = 1'b1;
    fm_manual = 1'b1;
    @(negedge wclk);
    p0 = pulses;
    send(51'h3_CAFE_0000_BEEF, 1'b0);
    repeat (5) @(negedge wclk);
    chk("blk_no_push", 64'(pulses - p0), 64'd0);
    chk("blk_state", 64'(dbg_state), 64'(S_IDLE));
    chk("blk_busy", 64'(busy), 64'd1);
    hold_cd   = 0;
    fm_manual = 1'b0;
    @(negedge wclk);
    chk("blk_full_fell", 64'(fifo_wfull), 64'd0);
    chk("blk_push_wait", 64'(fifo_wpush), 64'd0);
    @(negedge wclk);
    chk("blk_push_now", 64'(fifo_wpush), 64'd1);
    wait_idle("blk_idle");
    chk("blk_cnt", 64'(push_cnt), 64'd9);

    // lost handshake: full flag never rises
    fm_never = 1'b1;
    send(51'h2_0000_1111_2222, 1'b0);
    @(negedge wclk);
    @(negedge wclk);
    chk("lost_wset", 64'(dbg_state), 64'(S_WSET));
    repeat (3) @(negedge wclk);
    chk("lost_err_early", 64'(err), 64'd0);
    @(negedge wclk);
    chk("lost_err", 64'(err), 64'd1);
    chk("lost_state_idle", 64'(dbg_state), 64'(S_IDLE));
    chk("lost_busy", 64'(busy), 64'd0);
    chk("lost_cnt", 64'(push_cnt), 64'd10);
    fm_never = 1'b0;
    send(51'h1_0000_3333_4444, 1'b0);
    wait_idle("lost_recover_idle");
    chk("lost_err_sticky", 64'(err), 64'd1);
    chk("lost_recover_cnt", 64'(push_cnt), 64'd11);

    // reset in WAIT_SET with a second beat parked in the hold register
    send(51'h6_AAAA_BBBB_CCCC, 1'b0);
    @(negedge wclk);
    @(negedge wclk);
    chk("mid_wset", 64'(dbg_state), 64'(S_WSET));
    s_valid = 1'b1;
    s_data  = 51'h7_0123_4567_89AB;
    @(negedge wclk);
    s_valid = 1'b0;
    chk("mid_hold_full", 64'(s_ready), 64'd0);
    wrst = 1'b1;
    #1;
    exp_q.delete();
    p0 = pulses;
    chk("mid_rst_s_ready", 64'(s_ready), 64'd1);
    chk("mid_rst_wpush", 64'(fifo_wpush), 64'd0);
    chk("mid_rst_wdata", 64'(fifo_wdata), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_cnt", 64'(push_cnt), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
    repeat (10) @(negedge wclk);
    chk("mid_no_push", 64'(pulses - p0), 64'd0);
    chk("mid_cnt_after", 64'(push_cnt), 64'd0);

    // counter wrap: preload near the top, then two beats
    force dut.r_push_cnt = 16'hFFFE;
    @(negedge wclk);
    release dut.r_push_cnt;
    @(negedge wclk);
    chk("wrap_preload", 64'(push_cnt), 64'hFFFE);
    send(51'h0_1234_0000_0001, 1'b0);
    wait_idle("wrap_idle1");
    chk("wrap_ffff", 64'(push_cnt), 64'hFFFF);
    send(51'h0_1234_0000_0002, 1'b0);
    wait_idle("wrap_idle2");
    chk("wrap_zero", 64'(push_cnt), 64'h0000);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
